// File: rtl/sat_add_arbiter_pkg.sv
// Shared definitions for the saturating-adder arbiter slice.
//   ADD_W    : datapath width of the shared adder
//   SAT_POS  : clamp value for positive overflow
//   SAT_NEG  : clamp value for negative overflow
//   state_t  : response-stage occupancy (EMPTY / FULL)
//   id_width : requester-index width, never below 1 bit
package sat_add_arbiter_pkg;

  localparam int unsigned ADD_W = 16;
  localparam logic [ADD_W-1:0] SAT_POS = 16'h7fff;
  localparam logic [ADD_W-1:0] SAT_NEG = 16'h8000;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic int unsigned id_width(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sat_add_arbiter_if.sv
// Request/response bus of the shared saturating adder.
//   req_valid/req_a/req_b/req_ready : per-requester operand handshake
//   rsp_valid/rsp_sum/rsp_id/rsp_sat/rsp_ready : single response channel
// Modports: master = requesters + consumer side, slave = the arbiter.
interface sat_add_arbiter_if
  import sat_add_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) ();

  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [ADD_W*NUM_REQ-1:0] req_a;
  logic [ADD_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic [ADD_W-1:0]         rsp_sum;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_sat;
  logic                     rsp_ready;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id, rsp_sat
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, rsp_sat
  );

endinterface

// File: rtl/sat_add_arbiter_cla.sv
// CLA_16bit: 16-bit carry-lookahead adder built from four 4-bit groups.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin, modulo 2^16
module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);

  logic [15:0] p;
  logic [15:0] c;
  logic [2:0]  grp_g;
  logic [2:0]  grp_p;
  logic [3:0]  grp_c;

  assign p = a ^ b;

  // Group generate/propagate only for the three groups feeding a carry-in;
  // the top group's carry out is not needed.
  always_comb begin
    grp_g = '0;
    grp_p = '1;
    for (int unsigned j = 0; j < 3; j++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        grp_g[j] = (a[4*j+k] & b[4*j+k]) | (p[4*j+k] & grp_g[j]);
        grp_p[j] = grp_p[j] & p[4*j+k];
      end
    end
  end

  always_comb begin
    grp_c[0] = cin;
    for (int unsigned j = 0; j < 3; j++)
      grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
  end

  always_comb begin
    c = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i % 4 == 0) c[i] = grp_c[i/4];
      else            c[i] = (a[i-1] & b[i-1]) | (p[i-1] & c[i-1]);
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/sat_add_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first asserted request at or after ptr.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   grant     : one-hot winner (zero when no request)
//   grant_idx : binary winner index (zero when no request)
module rr_arbiter
  import sat_add_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  always_comb begin
    logic        found;
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sat_add_arbiter.sv
// sat_add_arbiter: shares one saturating 16-bit adder among NUM_REQ requesters
// with round-robin arbitration and a single registered response stage.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : request/response handshake (slave side)
//   sat_count : saturated results delivered, sticks at all-ones
module sat_add_arbiter
  import sat_add_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sat_add_arbiter_if.slave     bus,
  output logic [ADD_W-1:0]     sat_count
);

  localparam int unsigned ID_W = id_width(NUM_REQ);

  state_t             state_q, state_n;
  logic               can_accept;
  logic               accept;
  logic               deliver;
  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    ptr_q;
  logic [ADD_W-1:0]   op_a, op_b, raw_sum, sat_sum;
  logic               ovf;
  logic [ADD_W-1:0]   sum_q;
  logic [ID_W-1:0]    id_q;
  logic               sat_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (grant_oh),
    .grant_idx (grant_idx)
  );

  assign op_a = bus.req_a[grant_idx*ADD_W +: ADD_W];
  assign op_b = bus.req_b[grant_idx*ADD_W +: ADD_W];

  CLA_16bit u_cla (
    .a   (op_a),
    .b   (op_b),
    .cin (1'b0),
    .sum (raw_sum)
  );

  assign ovf     = (op_a[ADD_W-1] == op_b[ADD_W-1]) & (raw_sum[ADD_W-1] != op_a[ADD_W-1]);
  assign sat_sum = ovf ? (op_a[ADD_W-1] ? SAT_NEG : SAT_POS) : raw_sum;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_n;
  end

  always_comb begin
    can_accept    = (state_q == EMPTY) | bus.rsp_ready;
    accept        = can_accept & (|bus.req_valid);
    deliver       = (state_q == FULL) & bus.rsp_ready;
    bus.req_ready = accept ? grant_oh : '0;
    state_n       = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_n = FULL;
      FULL:  if (bus.rsp_ready && !accept) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      id_q  <= '0;
      sat_q <= 1'b0;
      ptr_q <= '0;
    end else if (accept) begin
      sum_q <= sat_sum;
      id_q  <= grant_idx;
      sat_q <= ovf;
      ptr_q <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      sat_count <= '0;
    else if (deliver && sat_q && sat_count != '1)
      sat_count <= sat_count + 1'b1;
  end

  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sat   = sat_q;

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Randomized and directed bench for sat_add_arbiter against a behavioural model.
module tb_sat_add_arbiter;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sat_count;

  int vectors = 0;
  int errors  = 0;

  sat_add_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  sat_add_arbiter #(.NUM_REQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int          m_ptr;
  logic        m_valid;
  logic [15:0] m_sum;
  int          m_id;
  logic        m_sat;
  int          m_count;
  logic [3:0]  last_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_winner();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [15:0] a, input logic [15:0] b);
    bus.req_valid[i]       = v;
    bus.req_a[16*i +: 16]  = a;
    bus.req_b[16*i +: 16]  = b;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 16'h0, 16'h0);
  endtask

  // One clock: check combinational ready, advance model across the edge,
  // then check the registered outputs. Called at a falling edge.
  task automatic step();
    int          g, s;
    logic [3:0]  exp_rdy;
    logic        n_valid, n_sat, acc, dlv;
    logic [15:0] n_sum, a, b;
    int          n_id, n_ptr, n_count;
    #1;
    g = model_winner();
    acc = (!m_valid || bus.rsp_ready) && (g >= 0);
    exp_rdy = acc ? 4'(1 << g) : 4'b0;
    last_rdy = bus.req_ready;
    check("req_ready", {28'b0, bus.req_ready}, {28'b0, exp_rdy});
    n_valid = m_valid; n_sum = m_sum; n_id = m_id; n_sat = m_sat;
    n_ptr = m_ptr; n_count = m_count;
    if (rst) begin
      n_valid = 0; n_sum = 0; n_id = 0; n_sat = 0; n_ptr = 0; n_count = 0;
    end else begin
      dlv = m_valid && bus.rsp_ready;
      if (dlv && m_sat && m_count < 65535) n_count = m_count + 1;
      if (acc) begin
        a = bus.req_a[16*g +: 16];
        b = bus.req_b[16*g +: 16];
        s = int'($signed(a)) + int'($signed(b));
        n_sat = (s > 32767) || (s < -32768);
        n_sum = (s > 32767) ? 16'h7fff : (s < -32768) ? 16'h8000 : 16'(s);
        n_id = g; n_ptr = (g + 1) % NREQ; n_valid = 1;
      end else if (dlv) begin
        n_valid = 0;
      end
    end
    @(posedge clk);
    m_valid = n_valid; m_sum = n_sum; m_id = n_id; m_sat = n_sat;
    m_ptr = n_ptr; m_count = n_count;
    @(negedge clk);
    check("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, m_valid});
    check("rsp_sum",   {16'b0, bus.rsp_sum},   {16'b0, m_sum});
    check("rsp_id",    {30'b0, bus.rsp_id},    32'(m_id));
    check("rsp_sat",   {31'b0, bus.rsp_sat},   {31'b0, m_sat});
    check("sat_count", {16'b0, sat_count},     32'(m_count));
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] edges [6];
    edges = '{16'h7fff, 16'h8000, 16'hffff, 16'h0001, 16'h7000, 16'h9000};
    if ($urandom_range(3) == 0) return edges[$urandom_range(5)];
    return 16'($urandom);
  endfunction

  initial begin
    logic [15:0] held;
    int          ids [5];

    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    @(posedge clk);
    @(negedge clk);
    m_ptr = 0; m_valid = 0; m_sum = 0; m_id = 0; m_sat = 0; m_count = 0;
    step();
    check("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    rst = 1'b0;

    // Single request
    set_req(0, 1'b1, 16'h0003, 16'h0004);
    step();
    check("single_sum", {16'b0, bus.rsp_sum}, 32'h0007);
    check("single_id", {30'b0, bus.rsp_id}, 32'd0);
    clear_reqs();
    step();

    // Positive saturation, then delivery counts it
    set_req(2, 1'b1, 16'h7000, 16'h1000);
    step();
    check("pos_sat_sum", {16'b0, bus.rsp_sum}, 32'h7fff);
    check("pos_sat_flag", {31'b0, bus.rsp_sat}, 32'd1);
    clear_reqs();
    step();
    check("pos_sat_count", {16'b0, sat_count}, 32'd1);

    // Negative saturation and a non-saturating carry-out case
    set_req(1, 1'b1, 16'h8000, 16'hffff);
    step();
    check("neg_sat_sum", {16'b0, bus.rsp_sum}, 32'h8000);
    check("neg_sat_flag", {31'b0, bus.rsp_sat}, 32'd1);
    set_req(1, 1'b1, 16'hffff, 16'h0001);
    step();
    check("wrap_sum", {16'b0, bus.rsp_sum}, 32'h0000);
    check("wrap_flag", {31'b0, bus.rsp_sat}, 32'd0);
    check("neg_sat_count", {16'b0, sat_count}, 32'd2);

    // Reset mid-traffic, then round robin from requester 0
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 16'(i * 16 + 1), 16'(i));
    step();
    step();
    rst = 1'b1;
    step();
    step();
    check("mid_reset_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("mid_reset_count", {16'b0, sat_count}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      ids[k] = int'(bus.rsp_id);
      check("rr_no_bubble", {31'b0, bus.rsp_valid}, 32'd1);
    end
    check("rr_seq0", 32'(ids[0]), 32'd0);
    check("rr_seq1", 32'(ids[1]), 32'd1);
    check("rr_seq2", 32'(ids[2]), 32'd2);
    check("rr_seq3", 32'(ids[3]), 32'd3);
    check("rr_seq4", 32'(ids[4]), 32'd0);

    // Backpressure
    clear_reqs();
    step();
    step();
    set_req(3, 1'b1, 16'h1234, 16'h0101);
    bus.rsp_ready = 1'b0;
    step();
    held = bus.rsp_sum;
    check("bp_first", {16'b0, held}, 32'h1335);
    set_req(3, 1'b1, 16'h0010, 16'h0020);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_ready_low", {28'b0, last_rdy}, 32'd0);
      check("bp_hold", {16'b0, bus.rsp_sum}, {16'b0, held});
    end
    bus.rsp_ready = 1'b1;
    step();
    check("bp_release_ready", {28'b0, last_rdy}, 32'b1000);
    check("bp_new_sum", {16'b0, bus.rsp_sum}, 32'h0030);

    // Random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'($urandom_range(1)), rand_op(), rand_op());
      bus.rsp_ready = ($urandom_range(9) < 7);
      rst = ($urandom_range(99) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
